line_rasterizer: RTL and testbench

LINE_RASTERIZER -- requirements
Module: line_rasterizer

---
 rtl/line_rasterizer_pkg.sv | 21 ++
 rtl/line_step.sv | 56 +++++
 rtl/line_rasterizer.sv | 143 ++++++++++++++
 tb/tb_line_rasterizer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/line_rasterizer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : line_rasterizer_pkg
// Description : Shared FSM state encoding and default coordinate widths for
//               the Bresenham line rasterizer.
// Revision    : 1.0 - initial release
// ============================================================================
package line_rasterizer_pkg;

    localparam int c_XW_DEFAULT = 10;
    localparam int c_YW_DEFAULT = 9;

    // Two bits cover the three states; the fourth code falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/line_step.sv
`default_nettype none
// ============================================================================
// Module      : line_step
// Description : One combinational Bresenham step: evaluates e2 = 2*err against
//               dy/dx and produces the next cursor position and error term.
// Revision    : 1.0 - initial release
// ============================================================================
module line_step
    import line_rasterizer_pkg::*;
#(
    parameter int XW = c_XW_DEFAULT,
    parameter int YW = c_YW_DEFAULT,
    localparam int EW = ((XW > YW) ? XW : YW) + 2
) (
    input  logic [XW-1:0]        cur_x,
    input  logic [YW-1:0]        cur_y,
    input  logic                 sx_neg,
    input  logic                 sy_neg,
    input  logic signed [EW-1:0] err,
    input  logic signed [EW-1:0] dx,
    input  logic signed [EW-1:0] dy,
    output logic [XW-1:0]        nxt_x,
    output logic [YW-1:0]        nxt_y,
    output logic signed [EW-1:0] nxt_err
);

    // e2 carries one extra bit so doubling the error can never wrap.
    logic signed [EW:0] w_e2;
    logic signed [EW:0] w_dx_ext;
    logic signed [EW:0] w_dy_ext;
    logic               w_step_x;
    logic               w_step_y;

    assign w_e2     = {err, 1'b0};
    assign w_dx_ext = {dx[EW-1], dx};
    assign w_dy_ext = {dy[EW-1], dy};
    assign w_step_x = (w_e2 >= w_dy_ext);
    assign w_step_y = (w_e2 <= w_dx_ext);

    // Both axis updates are applied together when both conditions hold.
    always_comb begin
        nxt_err = err;
        nxt_x   = cur_x;
        nxt_y   = cur_y;
        if (w_step_x) begin
            nxt_err = nxt_err + dy;
            nxt_x   = sx_neg ? (cur_x - XW'(1)) : (cur_x + XW'(1));
        end
        if (w_step_y) begin
            nxt_err = nxt_err + dx;
            nxt_y   = sy_neg ? (cur_y - YW'(1)) : (cur_y + YW'(1));
        end
    end

endmodule
`default_nettype wire

// File: rtl/line_rasterizer.sv
`default_nettype none
// ============================================================================
// Module      : line_rasterizer
// Description : Streams the pixels of one line (x0,y0)->(x1,y1) using
//               Bresenham's algorithm over a valid/ready handshake, one pixel
//               per cycle while the consumer is ready.
// Revision    : 1.0 - initial release
// ============================================================================
module line_rasterizer
    import line_rasterizer_pkg::*;
#(
    parameter int XW = c_XW_DEFAULT,
    parameter int YW = c_YW_DEFAULT,
    localparam int W  = (XW > YW) ? XW : YW,
    localparam int CW = W + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pix_count
);

    localparam int EW = W + 2;

    state_t               r_state;
    logic [XW-1:0]        r_x;
    logic [YW-1:0]        r_y;
    logic [XW-1:0]        r_x_end;
    logic [YW-1:0]        r_y_end;
    logic signed [EW-1:0] r_err;
    logic signed [EW-1:0] r_dx;
    logic signed [EW-1:0] r_dy;
    logic                 r_sx_neg;
    logic                 r_sy_neg;
    logic [CW-1:0]        r_count;

    logic [XW-1:0]        w_adx;
    logic [YW-1:0]        w_ady;
    logic signed [EW-1:0] w_dx_init;
    logic signed [EW-1:0] w_dy_init;
    logic [XW-1:0]        w_nxt_x;
    logic [YW-1:0]        w_nxt_y;
    logic signed [EW-1:0] w_nxt_err;
    logic                 w_at_end;

    // Absolute deltas at line setup; dy is kept negative as Bresenham expects.
    assign w_adx     = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
    assign w_ady     = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
    assign w_dx_init = EW'(w_adx);
    assign w_dy_init = -EW'(w_ady);
    assign w_at_end  = (r_x == r_x_end) && (r_y == r_y_end);

    line_step #(
        .XW (XW),
        .YW (YW)
    ) u_step (
        .cur_x   (r_x),
        .cur_y   (r_y),
        .sx_neg  (r_sx_neg),
        .sy_neg  (r_sy_neg),
        .err     (r_err),
        .dx      (r_dx),
        .dy      (r_dy),
        .nxt_x   (w_nxt_x),
        .nxt_y   (w_nxt_y),
        .nxt_err (w_nxt_err)
    );

    assign pix_x     = r_x;
    assign pix_y     = r_y;
    assign pix_count = r_count;
    assign pix_valid = (r_state == DRAW);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);

    // Line FSM: setup on start, one step per accepted pixel, abort wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_x_end  <= '0;
            r_y_end  <= '0;
            r_err    <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        r_x      <= x0;
                        r_y      <= y0;
                        r_x_end  <= x1;
                        r_y_end  <= y1;
                        r_dx     <= w_dx_init;
                        r_dy     <= w_dy_init;
                        r_err    <= w_dx_init + w_dy_init;
                        r_sx_neg <= !(x1 > x0);
                        r_sy_neg <= !(y1 > y0);
                        r_count  <= '0;
                        r_state  <= DRAW;
                    end
                end
                DRAW: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (pix_ready) begin
                        r_count <= r_count + CW'(1);
                        if (w_at_end) begin
                            r_state <= DONE;
                        end else begin
                            r_x   <= w_nxt_x;
                            r_y   <= w_nxt_y;
                            r_err <= w_nxt_err;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_rasterizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_rasterizer
// Description : Directed self-checking bench for line_rasterizer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_rasterizer;

    localparam int XW = 10;
    localparam int YW = 9;
    localparam int CW = 11;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [XW-1:0] x0, x1;
    logic [YW-1:0] y0, y1;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_valid;
    logic          pix_ready;
    logic          busy;
    logic          done;
    logic [CW-1:0] pix_count;

    int n_tests;
    int n_fail;

    int px_q[$];
    int py_q[$];
    int done_cyc;

    // Hand-computed Bresenham sequence for (1,1)->(12,5).
    int exp_x12[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
    int exp_y12[12] = '{1, 1, 2, 2, 2, 3, 3, 4, 4, 4, 5, 5};

    line_rasterizer #(
        .XW (XW),
        .YW (YW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .x0        (x0),
        .x1        (x1),
        .y0        (y0),
        .y1        (y1),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .busy      (busy),
        .done      (done),
        .pix_count (pix_count)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Draws one line, collecting accepted pixels; cycle 0 is the start cycle.
    task automatic draw(input int ax0, input int ay0, input int ax1, input int ay1, input bit toggle);
        int cyc;
        bit prev_stall;
        int hx, hy;
        x0 = XW'(ax0); y0 = YW'(ay0); x1 = XW'(ax1); y1 = YW'(ay1);
        start = 1'b1;
        pix_ready = 1'b1;
        px_q.delete();
        py_q.delete();
        done_cyc = -1;
        prev_stall = 1'b0;
        hx = 0;
        hy = 0;
        cyc = 0;
        while (cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (prev_stall) begin
                check_eq("stall_x", 32'(pix_x), 32'(hx));
                check_eq("stall_y", 32'(pix_y), 32'(hy));
            end
            prev_stall = 1'b0;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (pix_valid) begin
                pix_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
                if (pix_ready) begin
                    px_q.push_back(int'(pix_x));
                    py_q.push_back(int'(pix_y));
                end else begin
                    prev_stall = 1'b1;
                    hx = int'(pix_x);
                    hy = int'(pix_y);
                end
            end
        end
        pix_ready = 1'b1;
        if (done_cyc < 0) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_line12(input string tag);
        check_eq({tag, "_n"}, 32'(px_q.size()), 32'd12);
        if (px_q.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                check_eq({tag, "_x"}, 32'(px_q[i]), 32'(exp_x12[i]));
                check_eq({tag, "_y"}, 32'(py_q[i]), 32'(exp_y12[i]));
            end
        end
        check_eq({tag, "_cnt"}, 32'(pix_count), 32'd12);
    endtask

    initial begin
        int n;
        bit saw_done;
        n_tests = 0;
        n_fail = 0;
        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        pix_ready = 1'b1;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0;

        // Reset state, before any clock edge.
        #1;
        check_eq("rst_valid", 32'(pix_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_x", 32'(pix_x), 32'd0);
        check_eq("rst_y", 32'(pix_y), 32'd0);
        check_eq("rst_cnt", 32'(pix_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Abort in IDLE blocks start.
        x0 = 10'd3; y0 = 9'd3; x1 = 10'd9; y1 = 9'd9;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check_eq("idle_abort_busy", 32'(busy), 32'd0);
        check_eq("idle_abort_valid", 32'(pix_valid), 32'd0);

        // (1,1)->(12,5), ready held high.
        draw(1, 1, 12, 5, 1'b0);
        check_line12("l12");
        check_eq("l12_done_cyc", 32'(done_cyc), 32'd13);
        @(posedge clk); #1;
        check_eq("l12_done_pulse", 32'(done), 32'd0);
        check_eq("l12_busy_after", 32'(busy), 32'd0);

        // Same line with ready toggling every cycle.
        draw(1, 1, 12, 5, 1'b1);
        check_line12("tog");
        @(posedge clk); #1;

        // Vertical line (2,2)->(2,100).
        draw(2, 2, 2, 100, 1'b0);
        check_eq("vert_n", 32'(px_q.size()), 32'd99);
        for (int i = 0; i < px_q.size(); i++) begin
            check_eq("vert_x", 32'(px_q[i]), 32'd2);
            check_eq("vert_y", 32'(py_q[i]), 32'(2 + i));
        end
        check_eq("vert_cnt", 32'(pix_count), 32'd99);
        @(posedge clk); #1;

        // Reversed direction (150,300)->(100,100).
        draw(150, 300, 100, 100, 1'b0);
        check_eq("rev_n", 32'(px_q.size()), 32'd201);
        for (int i = 0; i < px_q.size(); i++) begin
            check_eq("rev_y", 32'(py_q[i]), 32'(300 - i));
            if (i > 0) check_eq("rev_xstep", 32'((px_q[i] <= px_q[i-1]) && (px_q[i-1] - px_q[i] <= 1)), 32'd1);
        end
        if (px_q.size() > 0) begin
            check_eq("rev_first_x", 32'(px_q[0]), 32'd150);
            check_eq("rev_last_x", 32'(px_q[px_q.size()-1]), 32'd100);
        end
        check_eq("rev_cnt", 32'(pix_count), 32'd201);
        @(posedge clk); #1;

        // Abort after the 5th accepted pixel of (0,0)->(50,20).
        x0 = 10'd0; y0 = 9'd0; x1 = 10'd50; y1 = 9'd20;
        start = 1'b1;
        pix_ready = 1'b1;
        n = 0;
        saw_done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) saw_done = 1'b1;
            if (pix_valid) begin
                if (n == 5) begin
                    abort = 1'b1;
                    break;
                end
                n++;
            end
        end
        check_eq("abort_reached", 32'(abort), 32'd1);
        @(posedge clk); #1;
        abort = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_valid", 32'(pix_valid), 32'd0);
        check_eq("abort_done", 32'(done | saw_done), 32'd0);
        check_eq("abort_cnt", 32'(pix_count), 32'd5);

        // Reset asserted mid-line clears outputs without a clock.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("mrst_valid", 32'(pix_valid), 32'd0);
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_eq("mrst_done", 32'(done), 32'd0);
        check_eq("mrst_x", 32'(pix_x), 32'd0);
        check_eq("mrst_y", 32'(pix_y), 32'd0);
        check_eq("mrst_cnt", 32'(pix_count), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Single-pixel line (7,7)->(7,7) after reset release.
        draw(7, 7, 7, 7, 1'b0);
        check_eq("pt_n", 32'(px_q.size()), 32'd1);
        if (px_q.size() == 1) begin
            check_eq("pt_x", 32'(px_q[0]), 32'd7);
            check_eq("pt_y", 32'(py_q[0]), 32'd7);
        end
        check_eq("pt_done_cyc", 32'(done_cyc), 32'd2);
        check_eq("pt_cnt", 32'(pix_count), 32'd1);
        @(posedge clk); #1;
        check_eq("pt_busy_after", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
